bcd2bin: RTL and testbench
==========================

Name: bcd2bin

Overview:
Multi-cycle packed-BCD to unsigned binary converter using the reverse double-dabble algorithm (shift-right, subtract-3).
- Inverse of the team's binary-to-BCD converter; default widths (6 digits / 20 bits) match it, so a round trip is lossless.
- Sits between decimal-entry front ends (keypad, UART decimal parser, register writes) and binary datapaths.
- Uses the same start/busy style handshake as the forward converter, plus a done pulse and registered result.

Parameters:
- DIGITS, 6, number of BCD digits on bcd_i (4 bits each). Input width DW = 4*DIGITS.
- BIN_W, 20, result width; also the number of shift iterations. Must satisfy 2^BIN_W > 10^DIGITS-1. Elaboration error otherwise.

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start_i, input, 1, request; sampled only when idle.
- bcd_i, input, DW, packed BCD; digit k at bits [4k+3:4k]; sampled with an accepted start.
- busy_o, output, 1, high while a conversion is in progress.
- done_o, output, 1, one-cycle pulse when bin_o updates.
- bin_o, output, BIN_W, registered result; holds until the next done_o.
- err_o, output, 1, invalid-digit flag; valid with done_o and held with bin_o.

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset state: state=IDLE; busy_o=0, done_o=0, bin_o=0, err_o=0; internal bcd_buf, bin_buf and cnt cleared.
- States:
  - IDLE: if start_i=1 at an edge, latch bcd_buf<=bcd_i, bin_buf<=0, cnt<=0, go to SHIFT. Otherwise stay.
  - SHIFT: {bcd_buf,bin_buf} <= {bcd_buf,bin_buf}>>1; bcd_buf LSB enters bin_buf MSB; zero enters bcd_buf MSB. cnt<=cnt+1.
    - If cnt==BIN_W-1 (final shift): bin_o<=shifted bin_buf, done_o<=1, go to IDLE.
    - Else go to ADJ.
  - ADJ: for every digit in bcd_buf in parallel, if digit>=8 then digit<=digit-3 (4-bit, no inter-digit borrow). Go to SHIFT.
- Iteration count: BIN_W shifts and BIN_W-1 adjusts.
  - Start accepted at edge E0 gives done_o high in the cycle after edge E(2*BIN_W-1). Default: 39 cycles.
- busy_o = (state != IDLE). Registered state decode, no combinational path from start_i.
- done_o is high exactly one cycle. busy_o is already low in that cycle, so a start_i held high is accepted at the next edge (back-to-back throughput 2*BIN_W cycles).
- start_i while busy: ignored, no queueing, bcd_i not re-sampled.
- bcd_i changes after acceptance: no effect on the running conversion.
- bin_o and err_o change only on the final-SHIFT edge or on reset.
- Reset mid-conversion: immediate abort; all outputs return to reset values; no done_o is produced.
- cnt width: clog2(BIN_W+1); no wrap within one conversion.

Optional Feature:
- Macro: BCD2BIN_DIGIT_CHECK_EN.
- When defined:
  - On start acceptance, a sticky bad flag is set if any input digit exceeds 9.
  - The conversion runs with normal latency.
  - On the final shift: err_o<=bad; bin_o<=0 if bad, else the converted value.
- When undefined:
  - err_o is tied to 0.
  - Invalid digits are processed by the algorithm unchanged; bin_o is deterministic but not meaningful.
  - No checking logic is synthesised.

Test Plan:
- Reset, then start with bcd_i=24'h000000 -> done_o 39 cycles after the start edge; bin_o=20'h00000, err_o=0, busy_o high 39 cycles.
- bcd_i=24'h999999 -> bin_o=20'hF423F. Then bcd_i=24'h123456 -> bin_o=20'h1E240. Then bcd_i=24'h000010 -> bin_o=20'h0000A.
- start_i held high continuously with bcd_i=24'h000001, then 24'h000002 -> done pulses every 40 cycles; bin_o=1 then 2; bcd_i changes mid-conversion do not affect the result.
- Start with 24'h654321; pulse start_i with 24'h111111 at cycle 10 -> ignored; single done_o with bin_o=20'h9FBF1.
- Start with 24'h999999; assert rst_n=0 at cycle 20 -> busy_o, done_o, bin_o, err_o immediately 0; no done_o after reset release.
- With BCD2BIN_DIGIT_CHECK_EN: bcd_i=24'h00000A -> err_o=1, bin_o=0 at done_o. Without the macro: err_o=0.

Source files
------------

// File: rtl/bcd2bin.sv
// rtl/bcd2bin.sv - multi-cycle packed-BCD to unsigned binary converter
//
// Reverse double-dabble: the BCD word and the binary accumulator form one
// long register that is shifted right one bit per SHIFT cycle.  Between
// shifts, every BCD digit that reads 8 or more has 3 subtracted (ADJ cycle),
// undoing the halving of the decimal weight that crossed a digit boundary.
// BIN_W shifts and BIN_W-1 adjusts give a result 2*BIN_W-1 cycles after start.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start_i  - conversion request, sampled only while idle
//   bcd_i    - packed BCD input, digit k at bits [4k+3:4k], sampled with start
//   busy_o   - high while a conversion is running
//   done_o   - one-cycle pulse when bin_o/err_o update
//   bin_o    - registered binary result, held until the next done_o
//   err_o    - invalid-digit flag, valid with done_o and held with bin_o
//
// Build option: define BCD2BIN_DIGIT_CHECK_EN to flag input digits above 9
// (err_o=1, bin_o=0).  Without it err_o is tied low and no check logic exists.

module bcd2bin #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   bcd_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [BIN_W-1:0]      bin_o,
    output logic                  err_o
);

    localparam int DW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Largest decimal value DIGITS digits can hold; the result must fit it.
    function automatic longint unsigned max_dec(input int d);
        longint unsigned v;
        v = 1;
        for (int i = 0; i < d; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

    localparam longint unsigned MAX_DEC = max_dec(DIGITS);

    generate
        if (BIN_W < 64) begin : g_width_check
            if ((64'd1 << BIN_W) <= MAX_DEC) begin : g_width_error
                $error("bcd2bin: BIN_W too small to hold the largest %0d-digit value", DIGITS);
            end
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ADJ   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      bcd_buf_q, bcd_buf_d;
    logic [BIN_W-1:0]   bin_buf_q, bin_buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               done_q, done_d;

    logic [DW-1:0]      bcd_shift;
    logic [BIN_W-1:0]   bin_shift;
    logic [DW-1:0]      bcd_adj;
    logic               last_shift;

    // One combined right shift: bcd LSB falls into bin MSB, zero enters bcd MSB.
    assign {bcd_shift, bin_shift} = {bcd_buf_q, bin_buf_q} >> 1;

    // Per-digit correction, digits independent (no borrow between them).
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_adj
            assign bcd_adj[4*k +: 4] = (bcd_buf_q[4*k +: 4] >= 4'd8)
                                     ? (bcd_buf_q[4*k +: 4] - 4'd3)
                                     : bcd_buf_q[4*k +: 4];
        end
    endgenerate

    assign last_shift = (state_q == S_SHIFT) && (cnt_q == CNT_W'(BIN_W - 1));

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic bad_q, bad_d;
    logic err_q, err_d;
    logic [DIGITS-1:0] digit_bad;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_chk
            assign digit_bad[k] = (bcd_i[4*k +: 4] > 4'd9);
        end
    endgenerate
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_SHIFT;
            S_SHIFT: state_d = last_shift ? S_IDLE : S_ADJ;
            S_ADJ:   state_d = S_SHIFT;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        busy_o = (state_q != S_IDLE);
    end

    // Datapath next-state
    always_comb begin
        bcd_buf_d = bcd_buf_q;
        bin_buf_d = bin_buf_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        done_d    = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        bad_d     = bad_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    bcd_buf_d = bcd_i;
                    bin_buf_d = '0;
                    cnt_d     = '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    bad_d     = |digit_bad;
`endif
                end
            end
            S_SHIFT: begin
                bcd_buf_d = bcd_shift;
                bin_buf_d = bin_shift;
                cnt_d     = cnt_q + CNT_W'(1);
                if (last_shift) begin
                    done_d = 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    bin_d  = bad_q ? '0 : bin_shift;
                    err_d  = bad_q;
`else
                    bin_d  = bin_shift;
`endif
                end
            end
            S_ADJ: begin
                bcd_buf_d = bcd_adj;
            end
            default: begin
                bcd_buf_d = bcd_buf_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_buf_q <= '0;
            bin_buf_q <= '0;
            cnt_q     <= '0;
            bin_q     <= '0;
            done_q    <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            bad_q     <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            bcd_buf_q <= bcd_buf_d;
            bin_buf_q <= bin_buf_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            done_q    <= done_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            bad_q     <= bad_d;
            err_q     <= err_d;
`endif
        end
    end

    assign done_o = done_q;
    assign bin_o  = bin_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    assign err_o  = err_q;
`else
    assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin.sv
// tb/tb_bcd2bin.sv - self-checking bench for bcd2bin

module tb_bcd2bin;

    localparam int DIGITS = 6;
    localparam int BIN_W  = 20;
    localparam int DW     = 4 * DIGITS;
    localparam int LAT    = 2 * BIN_W - 1;

`ifdef BCD2BIN_DIGIT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic [DW-1:0]    bcd_i = '0;
    logic             busy_o;
    logic             done_o;
    logic [BIN_W-1:0] bin_o;
    logic             err_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .bcd_i   (bcd_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bin_o   (bin_o),
        .err_o   (err_o)
    );

    typedef struct {
        logic [DW-1:0]    bcd;
        logic [BIN_W-1:0] bin;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Decimal value of the packed digits, most significant digit first.
    function automatic int ref_value(input logic [DW-1:0] b);
        int v;
        v = 0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            v = v * 10 + int'(b[4*k +: 4]);
        end
        return v;
    endfunction

    function automatic bit ref_bad(input logic [DW-1:0] b);
        bit bad;
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (b[4*k +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // One isolated conversion; bcd_i is scrambled right after acceptance.
    task automatic do_conv(input logic [DW-1:0] b, output logic [BIN_W-1:0] r_bin,
                           output logic r_err, output int lat, output int busy_cnt);
        @(negedge clk);
        start_i = 1'b1;
        bcd_i   = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        bcd_i   = ~b;
        lat = 0;
        busy_cnt = 0;
        while (1) begin
            @(negedge clk);
            if (done_o) break;
            if (busy_o) busy_cnt++;
            if (lat >= 100) break;
            @(posedge clk);
            lat++;
        end
        r_bin = bin_o;
        r_err = err_o;
        check("busy_low_at_done", {63'd0, busy_o}, 64'd0);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done_o}, 64'd0);
    endtask

    vec_t             vecs[5];
    logic [BIN_W-1:0] r_bin;
    logic             r_err;
    int               lat, bcnt, cyc, ndone, first_done;
    int               dt[2];
    logic [BIN_W-1:0] db[2];
    logic [DW-1:0]    rb;

    initial begin
        vecs[0] = '{24'h000000, 20'h00000};
        vecs[1] = '{24'h999999, 20'hF423F};
        vecs[2] = '{24'h123456, 20'h1E240};
        vecs[3] = '{24'h000010, 20'h0000A};
        vecs[4] = '{24'h654321, 20'h9FBF1};

        // Reset state
        #12;
        check("reset_busy", {63'd0, busy_o}, 64'd0);
        check("reset_done", {63'd0, done_o}, 64'd0);
        check("reset_bin",  {44'd0, bin_o}, 64'd0);
        check("reset_err",  {63'd0, err_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 5; i++) begin
            do_conv(vecs[i].bcd, r_bin, r_err, lat, bcnt);
            check($sformatf("tbl%0d_bin", i), {44'd0, r_bin}, {44'd0, vecs[i].bin});
            check($sformatf("tbl%0d_err", i), {63'd0, r_err}, 64'd0);
            check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(LAT));
            check($sformatf("tbl%0d_busy", i), 64'(bcnt), 64'(LAT));
        end

        // Back-to-back with start held high
        @(negedge clk);
        start_i = 1'b1;
        bcd_i   = 24'h000001;
        @(posedge clk);
        #1 bcd_i = 24'h000002;
        cyc = 0;
        ndone = 0;
        while (cyc < 120 && ndone < 2) begin
            @(negedge clk);
            if (done_o) begin
                dt[ndone] = cyc;
                db[ndone] = bin_o;
                ndone++;
            end
            @(posedge clk);
            cyc++;
            if (cyc == LAT + 1) begin
                #1;
                bcd_i   = 24'h000003;
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        check("b2b_count", 64'(ndone), 64'd2);
        check("b2b_t0", 64'(dt[0]), 64'(LAT));
        check("b2b_t1", 64'(dt[1]), 64'(2 * LAT + 1));
        check("b2b_bin0", {44'd0, db[0]}, 64'd1);
        check("b2b_bin1", {44'd0, db[1]}, 64'd2);
        repeat (3) @(negedge clk);
        check("b2b_idle", {62'd0, busy_o, done_o}, 64'd0);

        // Start while busy is ignored
        @(negedge clk);
        start_i = 1'b1;
        bcd_i   = 24'h654321;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        bcd_i   = '0;
        cyc = 0;
        ndone = 0;
        first_done = -1;
        while (cyc < 100) begin
            @(negedge clk);
            if (done_o) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = cyc;
                    r_bin = bin_o;
                end
            end
            if (cyc == 10) begin
                start_i = 1'b1;
                bcd_i   = 24'h111111;
            end
            if (cyc == 11) start_i = 1'b0;
            @(posedge clk);
            cyc++;
        end
        check("ign_count", 64'(ndone), 64'd1);
        check("ign_lat", 64'(first_done), 64'(LAT));
        check("ign_bin", {44'd0, r_bin}, 64'h9FBF1);

        // Reset mid-conversion
        @(negedge clk);
        start_i = 1'b1;
        bcd_i   = 24'h999999;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_busy_before", {63'd0, busy_o}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_bin",  {44'd0, bin_o}, 64'd0);
        check("rst_err",  {63'd0, err_o}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        bcnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (done_o) ndone++;
            if (busy_o) bcnt++;
        end
        check("rst_no_done", 64'(ndone), 64'd0);
        check("rst_no_busy", 64'(bcnt), 64'd0);

        // Invalid digit
        do_conv(24'h00000A, r_bin, r_err, lat, bcnt);
        check("inv_err", {63'd0, r_err}, {63'd0, CHK});
        check("inv_lat", 64'(lat), 64'(LAT));
`ifdef BCD2BIN_DIGIT_CHECK_EN
        check("inv_bin", {44'd0, r_bin}, 64'd0);
`endif

        // Randomized against the decimal reference model
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < DIGITS; k++) begin
                rb[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 5) == 0) begin
                rb[4*$urandom_range(0, DIGITS - 1) +: 4] = 4'($urandom_range(10, 15));
            end
            do_conv(rb, r_bin, r_err, lat, bcnt);
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(LAT));
            check($sformatf("rnd%0d_err", i), {63'd0, r_err}, {63'd0, CHK & ref_bad(rb)});
            if (!ref_bad(rb)) begin
                check($sformatf("rnd%0d_bin", i), {44'd0, r_bin}, 64'(ref_value(rb)));
            end
`ifdef BCD2BIN_DIGIT_CHECK_EN
            else begin
                check($sformatf("rnd%0d_bin_bad", i), {44'd0, r_bin}, 64'd0);
            end
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
